// File: rtl/wb_burst_ram_if.sv
// rtl/wb_burst_ram_if.sv - Wishbone B3 signal bundle between a bus master and wb_burst_ram
interface wb_burst_ram_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_burst_ram.sv
// rtl/wb_burst_ram.sv - Wishbone B3 slave RAM with registered-feedback bursts, wait states and an error window
module wb_burst_ram #(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_BASE    = 32'hFFFF_FFFF,
  parameter int unsigned ERR_SIZE    = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  wb_burst_ram_if.slave wb
);
  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, XFER, BURST, ERR} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [IW-1:0] beat_q, beat_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q, dat_d;

  logic [DW-1:0] mem [DEPTH];

  logic          req;
  logic          in_err;
  logic          oor;
  logic          is_burst;
  logic          first;
  logic          acc;
  logic [IW-1:0] acc_addr;
  logic [IW-1:0] adr_idx;
  logic [IW:0]   nxt;
  logic [63:0]   adr_ext;
  logic [AW-1:0] word_full;

  // Bit IW of the result is the carry out of a linear increment past the last word.
  function automatic logic [IW:0] next_beat(input logic [IW-1:0] a,
                                            input logic [2:0]    cti,
                                            input logic [1:0]    bte);
    logic [IW-1:0] mask;
    if (cti != 3'b010) return {1'b0, a};
    case (bte)
      2'b01:   mask = IW'(3);
      2'b10:   mask = IW'(7);
      2'b11:   mask = IW'(15);
      default: return {1'b0, a} + (IW+1)'(1);
    endcase
    return {1'b0, (a & ~mask) | ((a + IW'(1)) & mask)};
  endfunction

  assign req       = wb.wb_cyc_i && wb.wb_stb_i;
  assign adr_ext   = 64'(wb.wb_adr_i);
  assign in_err    = (ERR_SIZE != 0) && (adr_ext >= 64'(ERR_BASE)) &&
                     (adr_ext < 64'(ERR_BASE) + 64'(ERR_SIZE));
  assign word_full = wb.wb_adr_i >> OFF;
  assign oor       = (word_full >> IW) != '0;
  assign adr_idx   = wb.wb_adr_i[OFF +: IW];
  assign is_burst  = (wb.wb_cti_i == 3'b001) || (wb.wb_cti_i == 3'b010);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    first    = 1'b0;
    acc      = 1'b0;
    acc_addr = beat_q;
    nxt      = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (in_err || oor) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            first = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else if (wcnt_q > 4'd1) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (wb.wb_stb_i) begin
          wcnt_d = '0;
          first  = 1'b1;
        end
      end
      BURST: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else if (wb.wb_stb_i) begin
          if (ovf_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            acc = 1'b1;
            if (!is_burst) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The first beat of any transfer addresses the bus; later beats use the tracked address.
    if (first) begin
      acc      = 1'b1;
      acc_addr = adr_idx;
      state_d  = is_burst ? BURST : XFER;
    end

    if (acc) begin
      ack_d  = 1'b1;
      dat_d  = mem[acc_addr];
      nxt    = next_beat(acc_addr, wb.wb_cti_i, wb.wb_bte_i);
      beat_d = nxt[IW-1:0];
      ovf_d  = nxt[IW];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Contents survive reset; only the beat being acked at this edge is written.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_ni && acc && wb.wb_we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wb.wb_sel_i[b]) mem[acc_addr][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;
endmodule

// File: tb/tb_wb_burst_ram.sv
// tb/tb_wb_burst_ram.sv - directed bench for wb_burst_ram (zero and three wait states, error window)
module tb_wb_burst_ram;
  logic        clk;
  logic        rst_n;
  logic        use_b;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_we;
  logic        m_cyc;
  logic        m_stb;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;

  logic [31:0] b_adr [8];
  logic [31:0] b_dat [8];
  logic [2:0]  b_cti [8];
  logic [31:0] b_rd  [8];

  int checks = 0;
  int errors = 0;

  wb_burst_ram_if #(.DW(32), .AW(32)) if_a ();
  wb_burst_ram_if #(.DW(32), .AW(32)) if_b ();

  assign if_a.wb_adr_i = m_adr;
  assign if_a.wb_dat_i = m_dat;
  assign if_a.wb_sel_i = m_sel;
  assign if_a.wb_we_i  = m_we;
  assign if_a.wb_cyc_i = m_cyc;
  assign if_a.wb_stb_i = m_stb;
  assign if_a.wb_cti_i = m_cti;
  assign if_a.wb_bte_i = m_bte;
  assign if_b.wb_adr_i = m_adr;
  assign if_b.wb_dat_i = m_dat;
  assign if_b.wb_sel_i = m_sel;
  assign if_b.wb_we_i  = m_we;
  assign if_b.wb_cyc_i = m_cyc;
  assign if_b.wb_stb_i = m_stb;
  assign if_b.wb_cti_i = m_cti;
  assign if_b.wb_bte_i = m_bte;

  wb_burst_ram #(.DW(32), .AW(32), .DEPTH(16384), .WAIT_STATES(0),
                 .ERR_BASE(32'h8000), .ERR_SIZE(32'h100)) u_ram_a (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (if_a)
  );

  wb_burst_ram #(.DW(32), .AW(32), .DEPTH(16384), .WAIT_STATES(3),
                 .ERR_BASE(32'h8000), .ERR_SIZE(32'h100)) u_ram_b (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (if_b)
  );

  logic        o_ack;
  logic        o_err;
  logic [31:0] o_dat;
  assign o_ack = use_b ? if_b.wb_ack_o : if_a.wb_ack_o;
  assign o_err = use_b ? if_b.wb_err_o : if_a.wb_err_o;
  assign o_dat = use_b ? if_b.wb_dat_o : if_a.wb_dat_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_cti = 3'b000;
    m_bte = 2'b00;
  endtask

  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat,
                         output logic ack, output logic err);
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we;
    m_cti = 3'b000; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
    lat = 0; ack = 1'b0; err = 1'b0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (o_ack || o_err) begin
        ack = o_ack;
        err = o_err;
        break;
      end
    end
    rd = o_dat;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic run_burst(input logic we, input int n, input logic [1:0] bte, input int abort_at,
                           output int acks, output int errs, output int ncyc);
    int k;
    k = 0; acks = 0; errs = 0; ncyc = 0;
    m_we = we; m_bte = bte; m_sel = 4'hF;
    m_adr = b_adr[0]; m_dat = b_dat[0]; m_cti = b_cti[0];
    m_cyc = 1'b1; m_stb = 1'b1;
    while (k < n && ncyc < 40) begin
      @(posedge clk); #1;
      ncyc++;
      if (o_err) begin
        errs++;
        break;
      end
      if (o_ack) begin
        b_rd[k] = o_dat;
        acks++;
        k++;
        if (acks == abort_at) break;
        if (k < n) begin
          m_adr = b_adr[k]; m_dat = b_dat[k]; m_cti = b_cti[k];
        end
      end
    end
    bus_idle();
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, acks, errs, ncyc;
    logic        ack, err;
    logic [9:0]  pa, pb;

    use_b = 1'b0; rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = 4'hF;
    bus_idle();

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_a", 32'(if_a.wb_ack_o), 32'h0);
    check("rst_err_a", 32'(if_a.wb_err_o), 32'h0);
    check("rst_rty_a", 32'(if_a.wb_rty_o), 32'h0);
    check("rst_dat_a", if_a.wb_dat_o, 32'h0);
    check("rst_ack_b", 32'(if_b.wb_ack_o), 32'h0);
    check("rst_dat_b", if_b.wb_dat_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ack, err);
    check("wr_lat", 32'(lat), 32'd1);
    check("wr_ack", 32'({ack, err}), 32'h2);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ack, err);
    check("rd_lat", 32'(lat), 32'd1);
    check("rd_data", rd, 32'hDEADBEEF);
    classic(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, lat, ack, err);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ack, err);
    check("byte_wr_data", rd, 32'hDEADAAEF);

    use_b = 1'b1;
    classic(1'b1, 32'h40, 32'h12345678, 4'hF, rd, lat, ack, err);
    check("ws3_wr_lat", 32'(lat), 32'd4);
    classic(1'b0, 32'h40, 32'h0, 4'hF, rd, lat, ack, err);
    check("ws3_rd_lat", 32'(lat), 32'd4);
    check("ws3_rd_data", rd, 32'h12345678);
    classic(1'b0, 32'h8004, 32'h0, 4'hF, rd, lat, ack, err);
    check("ws3_err_lat", 32'(lat), 32'd1);
    check("ws3_err_flags", 32'({ack, err}), 32'h1);
    use_b = 1'b0;

    // Hold a classic read request continuously: acks must be separated by idle cycles.
    @(posedge clk); #1;
    m_adr = 32'h10; m_we = 1'b0; m_sel = 4'hF; m_cti = 3'b000; m_cyc = 1'b1; m_stb = 1'b1;
    pa = '0; pb = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      pa[k] = if_a.wb_ack_o;
      pb[k] = if_b.wb_ack_o;
    end
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    check("ws0_ack_pattern", 32'(pa), 32'h155);
    check("ws3_ack_pattern", 32'(pb), 32'h108);

    b_adr = '{32'h18, 32'h1C, 32'h10, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0};
    b_dat = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0};
    b_cti = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    run_burst(1'b1, 4, 2'b01, 0, acks, errs, ncyc);
    @(posedge clk); #1;
    check("wrap_wr_acks", 32'(acks), 32'd4);
    check("wrap_wr_cycles", 32'(ncyc), 32'd4);
    check("wrap_wr_errs", 32'(errs), 32'd0);
    classic(1'b0, 32'h18, 32'h0, 4'hF, rd, lat, ack, err); check("wrap_word6", rd, 32'h1);
    classic(1'b0, 32'h1C, 32'h0, 4'hF, rd, lat, ack, err); check("wrap_word7", rd, 32'h2);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ack, err); check("wrap_word4", rd, 32'h3);
    classic(1'b0, 32'h14, 32'h0, 4'hF, rd, lat, ack, err); check("wrap_word5", rd, 32'h4);

    b_adr = '{32'h1C, 32'h10, 32'h14, 32'h18, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(1'b0, 4, 2'b01, 0, acks, errs, ncyc);
    @(posedge clk); #1;
    check("wrap_rd_acks", 32'(acks), 32'd4);
    check("wrap_rd_beat0", b_rd[0], 32'h2);
    check("wrap_rd_beat1", b_rd[1], 32'h3);
    check("wrap_rd_beat2", b_rd[2], 32'h4);
    check("wrap_rd_beat3", b_rd[3], 32'h1);

    b_adr = '{32'hFFF8, 32'hFFFC, 32'h10000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    b_cti = '{3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    run_burst(1'b0, 3, 2'b00, 0, acks, errs, ncyc);
    check("lin_end_acks", 32'(acks), 32'd2);
    check("lin_end_errs", 32'(errs), 32'd1);
    check("lin_end_cycles", 32'(ncyc), 32'd3);
    @(posedge clk); #1;
    check("lin_end_quiet", 32'({if_a.wb_ack_o, if_a.wb_err_o}), 32'h0);

    classic(1'b0, 32'h8004, 32'h0, 4'hF, rd, lat, ack, err);
    check("errwin_lat", 32'(lat), 32'd1);
    check("errwin_flags", 32'({ack, err}), 32'h1);
    classic(1'b1, 32'h80FC, 32'h0BADBAD0, 4'hF, rd, lat, ack, err);
    check("errwin_last_flags", 32'({ack, err}), 32'h1);
    classic(1'b1, 32'h8100, 32'hCAFEF00D, 4'hF, rd, lat, ack, err);
    check("errwin_above_flags", 32'({ack, err}), 32'h2);
    classic(1'b0, 32'h8100, 32'h0, 4'hF, rd, lat, ack, err);
    check("errwin_above_data", rd, 32'hCAFEF00D);
    classic(1'b1, 32'h7FFC, 32'h0F0F0F0F, 4'hF, rd, lat, ack, err);
    check("errwin_below_flags", 32'({ack, err}), 32'h2);
    classic(1'b0, 32'h10000, 32'h0, 4'hF, rd, lat, ack, err);
    check("oor_flags", 32'({ack, err}), 32'h1);

    classic(1'b1, 32'h208, 32'h11111111, 4'hF, rd, lat, ack, err);
    classic(1'b1, 32'h20C, 32'h11111111, 4'hF, rd, lat, ack, err);
    for (int k = 0; k < 8; k++) begin
      b_adr[k] = 32'h200 + 32'(4 * k);
      b_dat[k] = 32'hA0 + 32'(k);
      b_cti[k] = (k == 7) ? 3'b111 : 3'b010;
    end
    run_burst(1'b1, 8, 2'b00, 2, acks, errs, ncyc);
    check("abort_acks", 32'(acks), 32'd2);
    @(posedge clk); #1;
    check("abort_ack_low", 32'(if_a.wb_ack_o), 32'h0);
    classic(1'b0, 32'h200, 32'h0, 4'hF, rd, lat, ack, err); check("abort_word0", rd, 32'hA0);
    classic(1'b0, 32'h204, 32'h0, 4'hF, rd, lat, ack, err); check("abort_word1", rd, 32'hA1);
    classic(1'b0, 32'h208, 32'h0, 4'hF, rd, lat, ack, err); check("abort_word2", rd, 32'h11111111);

    classic(1'b1, 32'h300, 32'h66666666, 4'hF, rd, lat, ack, err);
    classic(1'b1, 32'h304, 32'h55555555, 4'hF, rd, lat, ack, err);
    m_adr = 32'h300; m_dat = 32'h77; m_sel = 4'hF; m_we = 1'b1;
    m_cti = 3'b010; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    check("rst_burst_ack0", 32'(if_a.wb_ack_o), 32'h1);
    m_adr = 32'h304; m_dat = 32'h88;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_burst_ack", 32'(if_a.wb_ack_o), 32'h0);
    check("rst_burst_err", 32'(if_a.wb_err_o), 32'h0);
    check("rst_burst_dat", if_a.wb_dat_o, 32'h0);
    rst_n = 1'b1;
    bus_idle();
    @(posedge clk); #1;
    classic(1'b0, 32'h304, 32'h0, 4'hF, rd, lat, ack, err); check("rst_burst_unwritten", rd, 32'h55555555);
    classic(1'b0, 32'h300, 32'h0, 4'hF, rd, lat, ack, err); check("rst_burst_written", rd, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
